fuzz_wb_router: RTL and testbench

Downstream stage of the central fuzzer top. It accepts the fuzzer's Wishbone master traffic (wbm_* of the fuzzer) on a single Wishbone slave port and routes each classic single-beat transaction to one of IP_NUM IP Wishbone slave buses, decoded from the top address bits. It adds a per-transaction ack watchdog, so a hung or fuzzed-into-deadlock IP cannot stall the fuzzer. It also keeps transaction, timeout and hang-status statistics.

---
 rtl/fuzz_wb_router.sv | 224 ++++++++++++++++++++++
 tb/tb_fuzz_wb_router.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fuzz_wb_router.sv
// Routes single-beat Wishbone transactions from the fuzzer to one of IP_NUM IP buses,
// with a per-transaction ack watchdog and transaction/timeout/hang statistics.
module fuzz_wb_router #(
  parameter int                    ADDR_WIDTH        = 32,
  parameter int                    DATA_WIDTH        = 32,
  parameter int                    IP_NUM            = 4,
  parameter int                    IP_SELECTOR_WIDTH = 2,
  parameter int                    TIMEOUT_CYCLES    = 255,
  parameter int                    CNT_WIDTH         = 16,
  parameter logic [DATA_WIDTH-1:0] ERR_DATA          = 32'hDEAD_BEEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wbs_cyc_i,
  input  logic                         wbs_stb_i,
  input  logic                         wbs_we_i,
  input  logic [ADDR_WIDTH-1:0]        wbs_adr_i,
  input  logic [DATA_WIDTH-1:0]        wbs_dat_i,
  input  logic [DATA_WIDTH/8-1:0]      wbs_sel_i,
  output logic [DATA_WIDTH-1:0]        wbs_dat_o,
  output logic                         wbs_ack_o,
  output logic [IP_NUM-1:0]            ip_cyc_o,
  output logic [IP_NUM-1:0]            ip_stb_o,
  output logic                         ip_we_o,
  output logic [ADDR_WIDTH-1:0]        ip_adr_o,
  output logic [DATA_WIDTH-1:0]        ip_dat_o,
  output logic [DATA_WIDTH/8-1:0]      ip_sel_o,
  input  logic [IP_NUM*DATA_WIDTH-1:0] ip_dat_i,
  input  logic [IP_NUM-1:0]            ip_ack_i,
  input  logic                         clear_stats_i,
  output logic [CNT_WIDTH-1:0]         txn_count_o,
  output logic [CNT_WIDTH-1:0]         timeout_count_o,
  output logic [IP_NUM-1:0]            hang_flags_o,
  output logic                         err_o
);

  localparam int SEL_W = DATA_WIDTH / 8;
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, RESP} state_t;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  function automatic logic [IP_NUM-1:0] idx_onehot(input logic [IP_SELECTOR_WIDTH-1:0] idx);
    logic [IP_NUM-1:0] oh;
    oh = '0;
    for (int k = 0; k < IP_NUM; k++) oh[k] = (32'(idx) == 32'(k));
    return oh;
  endfunction

  state_t                       state_q, state_d;
  logic [IP_SELECTOR_WIDTH-1:0] tgt_q, tgt_d;
  logic [TMR_W-1:0]             timer_q, timer_d;
  logic [IP_NUM-1:0]            ip_cyc_q, ip_cyc_d;
  logic [IP_NUM-1:0]            ip_stb_q, ip_stb_d;
  logic                         ip_we_q, ip_we_d;
  logic [ADDR_WIDTH-1:0]        ip_adr_q, ip_adr_d;
  logic [DATA_WIDTH-1:0]        ip_dat_q, ip_dat_d;
  logic [SEL_W-1:0]             ip_sel_q, ip_sel_d;
  logic [DATA_WIDTH-1:0]        wbs_dat_q, wbs_dat_d;
  logic                         wbs_ack_q, wbs_ack_d;
  logic [CNT_WIDTH-1:0]         txn_q, txn_d;
  logic [CNT_WIDTH-1:0]         to_cnt_q, to_cnt_d;
  logic [IP_NUM-1:0]            hang_q, hang_d;
  logic                         err_q, err_d;

  logic [IP_SELECTOR_WIDTH-1:0] req_idx;
  logic                         req_valid;
  logic [IP_NUM-1:0]            tgt_oh;
  logic                         tgt_ack;
  logic [DATA_WIDTH-1:0]        tgt_rdata;
  logic                         txn_inc, to_inc;

  assign req_idx   = wbs_adr_i[ADDR_WIDTH-1 -: IP_SELECTOR_WIDTH];
  assign req_valid = (32'(req_idx) < 32'(IP_NUM));
  assign tgt_oh    = idx_onehot(tgt_q);
  assign tgt_ack   = |(ip_ack_i & tgt_oh);

  always_comb begin
    tgt_rdata = '0;
    for (int k = 0; k < IP_NUM; k++) begin
      if (tgt_oh[k]) tgt_rdata = tgt_rdata | ip_dat_i[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    state_d   = state_q;
    tgt_d     = tgt_q;
    timer_d   = timer_q;
    ip_cyc_d  = ip_cyc_q;
    ip_stb_d  = ip_stb_q;
    ip_we_d   = ip_we_q;
    ip_adr_d  = ip_adr_q;
    ip_dat_d  = ip_dat_q;
    ip_sel_d  = ip_sel_q;
    wbs_dat_d = wbs_dat_q;
    wbs_ack_d = 1'b0;
    err_d     = 1'b0;
    hang_d    = hang_q;
    txn_inc   = 1'b0;
    to_inc    = 1'b0;

    case (state_q)
      IDLE: begin
        ip_cyc_d = '0;
        ip_stb_d = '0;
        if (wbs_cyc_i && wbs_stb_i) begin
          tgt_d    = req_idx;
          ip_we_d  = wbs_we_i;
          ip_adr_d = wbs_adr_i;
          ip_dat_d = wbs_dat_i;
          ip_sel_d = wbs_sel_i;
          timer_d  = '0;
          if (req_valid) begin
            ip_cyc_d = idx_onehot(req_idx);
            ip_stb_d = idx_onehot(req_idx);
            state_d  = ACTIVE;
          end else begin
            // Unmapped selector: answer locally so the fuzzer never waits on it.
            wbs_dat_d = ERR_DATA;
            wbs_ack_d = 1'b1;
            err_d     = 1'b1;
            state_d   = RESP;
          end
        end
      end

      ACTIVE: begin
        timer_d = timer_q + TMR_W'(1);
        if (!wbs_cyc_i) begin
          ip_cyc_d = '0;
          ip_stb_d = '0;
          state_d  = IDLE;
        end else if (tgt_ack) begin
          wbs_dat_d = tgt_rdata;
          wbs_ack_d = 1'b1;
          ip_cyc_d  = '0;
          ip_stb_d  = '0;
          state_d   = RESP;
        end else if (timer_q == TMR_LAST) begin
          wbs_dat_d = ERR_DATA;
          wbs_ack_d = 1'b1;
          err_d     = 1'b1;
          hang_d    = hang_q | tgt_oh;
          to_inc    = 1'b1;
          ip_cyc_d  = '0;
          ip_stb_d  = '0;
          state_d   = RESP;
        end
      end

      RESP: begin
        txn_inc = 1'b1;
        state_d = IDLE;
      end

      default: begin
        ip_cyc_d = '0;
        ip_stb_d = '0;
        state_d  = IDLE;
      end
    endcase

    txn_d    = txn_inc ? sat_inc(txn_q) : txn_q;
    to_cnt_d = to_inc ? sat_inc(to_cnt_q) : to_cnt_q;
    // Clearing statistics overrides any increment landing on the same edge.
    if (clear_stats_i) begin
      txn_d    = '0;
      to_cnt_d = '0;
      hang_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    tgt_q   <= tgt_d;
    timer_q <= timer_d;
    if (rst) begin
      state_q   <= IDLE;
      ip_cyc_q  <= '0;
      ip_stb_q  <= '0;
      ip_we_q   <= 1'b0;
      ip_adr_q  <= '0;
      ip_dat_q  <= '0;
      ip_sel_q  <= '0;
      wbs_dat_q <= '0;
      wbs_ack_q <= 1'b0;
      txn_q     <= '0;
      to_cnt_q  <= '0;
      hang_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ip_cyc_q  <= ip_cyc_d;
      ip_stb_q  <= ip_stb_d;
      ip_we_q   <= ip_we_d;
      ip_adr_q  <= ip_adr_d;
      ip_dat_q  <= ip_dat_d;
      ip_sel_q  <= ip_sel_d;
      wbs_dat_q <= wbs_dat_d;
      wbs_ack_q <= wbs_ack_d;
      txn_q     <= txn_d;
      to_cnt_q  <= to_cnt_d;
      hang_q    <= hang_d;
      err_q     <= err_d;
    end
  end

  assign wbs_dat_o       = wbs_dat_q;
  assign wbs_ack_o       = wbs_ack_q;
  assign ip_cyc_o        = ip_cyc_q;
  assign ip_stb_o        = ip_stb_q;
  assign ip_we_o         = ip_we_q;
  assign ip_adr_o        = ip_adr_q;
  assign ip_dat_o        = ip_dat_q;
  assign ip_sel_o        = ip_sel_q;
  assign txn_count_o     = txn_q;
  assign timeout_count_o = to_cnt_q;
  assign hang_flags_o    = hang_q;
  assign err_o           = err_q;

endmodule

// File: tb/tb_fuzz_wb_router.sv
// Scoreboard bench for fuzz_wb_router: IP responders with programmable ack delay,
// expected read data queued at request time and checked when wbs_ack_o appears.
module tb_fuzz_wb_router;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int NIP = 3;
  localparam int SW  = 2;
  localparam int TO  = 8;
  localparam int CW  = 2;
  localparam logic [DW-1:0] ERR = 32'hDEAD_BEEF;

  logic              clk = 1'b0;
  logic              rst;
  logic              wbs_cyc_i, wbs_stb_i, wbs_we_i;
  logic [AW-1:0]     wbs_adr_i;
  logic [DW-1:0]     wbs_dat_i;
  logic [DW/8-1:0]   wbs_sel_i;
  logic [DW-1:0]     wbs_dat_o;
  logic              wbs_ack_o;
  logic [NIP-1:0]    ip_cyc_o, ip_stb_o;
  logic              ip_we_o;
  logic [AW-1:0]     ip_adr_o;
  logic [DW-1:0]     ip_dat_o;
  logic [DW/8-1:0]   ip_sel_o;
  logic [NIP*DW-1:0] ip_dat;
  logic [NIP-1:0]    ip_ack_i;
  logic [NIP-1:0]    resp_ack, extra_ack;
  logic              clear_stats_i;
  logic [CW-1:0]     txn_count_o, timeout_count_o;
  logic [NIP-1:0]    hang_flags_o;
  logic              err_o;

  assign ip_ack_i = resp_ack | extra_ack;

  always #5 clk = ~clk;

  fuzz_wb_router #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .IP_NUM(NIP), .IP_SELECTOR_WIDTH(SW),
    .TIMEOUT_CYCLES(TO), .CNT_WIDTH(CW), .ERR_DATA(ERR)
  ) dut (
    .clk(clk), .rst(rst),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
    .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i), .wbs_sel_i(wbs_sel_i),
    .wbs_dat_o(wbs_dat_o), .wbs_ack_o(wbs_ack_o),
    .ip_cyc_o(ip_cyc_o), .ip_stb_o(ip_stb_o), .ip_we_o(ip_we_o),
    .ip_adr_o(ip_adr_o), .ip_dat_o(ip_dat_o), .ip_sel_o(ip_sel_o),
    .ip_dat_i(ip_dat), .ip_ack_i(ip_ack_i),
    .clear_stats_i(clear_stats_i),
    .txn_count_o(txn_count_o), .timeout_count_o(timeout_count_o),
    .hang_flags_o(hang_flags_o), .err_o(err_o)
  );

  typedef struct packed {
    logic [DW-1:0] dat;
    logic          chk;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   delay[NIP];
  int   ack_cnt = 0, err_cnt = 0, stb1_cnt = 0;
  logic [AW-1:0]   obs_adr;
  logic [DW-1:0]   obs_dat;
  logic [DW/8-1:0] obs_sel;
  logic            obs_we;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // IP responders: ack one cycle after `delay` strobe cycles; delay 0 never acks.
  initial begin
    int cnt[NIP];
    resp_ack = '0;
    for (int k = 0; k < NIP; k++) cnt[k] = 0;
    forever begin
      @(negedge clk);
      for (int k = 0; k < NIP; k++) begin
        if (resp_ack[k]) begin
          resp_ack[k] = 1'b0;
          cnt[k] = 0;
        end else if (ip_stb_o[k]) begin
          cnt[k]++;
          if (delay[k] != 0 && cnt[k] >= delay[k]) resp_ack[k] = 1'b1;
        end else begin
          cnt[k] = 0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (wbs_ack_o) ack_cnt++;
      if (err_o) err_cnt++;
      if (ip_stb_o[1]) stb1_cnt++;
    end
  end

  task automatic do_txn(input string tag, input logic [AW-1:0] adr, input logic we,
                        input logic [DW-1:0] dat, input logic [DW/8-1:0] sel,
                        input logic [DW-1:0] exp_dat, input logic chk_dat,
                        input logic [NIP-1:0] exp_stb, input int exp_lat, input bit clr_on_ack);
    exp_t e;
    bit got;
    int lat;
    logic [NIP-1:0] stb_or;
    e.dat = exp_dat;
    e.chk = chk_dat;
    sb.push_back(e);
    @(posedge clk); #1;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
    wbs_adr_i = adr; wbs_dat_i = dat; wbs_sel_i = sel;
    got = 0; lat = 0; stb_or = '0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      lat++;
      stb_or = stb_or | ip_stb_o;
      if (ip_stb_o != '0) begin
        obs_adr = ip_adr_o; obs_dat = ip_dat_o; obs_sel = ip_sel_o; obs_we = ip_we_o;
      end
      if (wbs_ack_o) begin
        got = 1;
        e = sb.pop_front();
        if (e.chk) check_val({tag, "_dat"}, 64'(wbs_dat_o), 64'(e.dat));
        if (clr_on_ack) clear_stats_i = 1'b1;
      end
    end
    if (!got) begin
      check_val({tag, "_ack_wait"}, 64'(0), 64'(1));
      e = sb.pop_front();
    end
    @(posedge clk); #1;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    clear_stats_i = 1'b0;
    check_val({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check_val({tag, "_stb"}, 64'(stb_or), 64'(exp_stb));
  endtask

  task automatic clear_pulse();
    @(posedge clk); #1; clear_stats_i = 1'b1;
    @(posedge clk); #1; clear_stats_i = 1'b0;
  endtask

  initial begin
    int a0, e0, s0;
    rst = 1'b1; clear_stats_i = 1'b0; extra_ack = '0;
    wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0;
    wbs_adr_i = '0; wbs_dat_i = '0; wbs_sel_i = '0; ip_dat = '0;
    for (int k = 0; k < NIP; k++) delay[k] = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_val("rst_wbs", 64'({wbs_ack_o, wbs_dat_o, err_o}), 64'(0));
    check_val("rst_ip", 64'({ip_cyc_o, ip_stb_o, ip_we_o, ip_adr_o}), 64'(0));
    check_val("rst_stats", 64'({txn_count_o, timeout_count_o, hang_flags_o}), 64'(0));

    // Read IP 2 with 3-cycle ack delay
    delay[2] = 3; ip_dat[2*DW +: DW] = 32'h1234_5678;
    e0 = err_cnt;
    do_txn("rd_ip2", 32'h8000_0010, 1'b0, '0, 4'hF, 32'h1234_5678, 1'b1, 3'b100, 5, 0);
    check_val("rd_ip2_txn", 64'(txn_count_o), 64'(1));
    check_val("rd_ip2_adr", 64'(obs_adr), 64'(32'h8000_0010));
    check_val("rd_ip2_we", 64'(obs_we), 64'(0));
    check_val("rd_ip2_noerr", 64'(err_cnt - e0), 64'(0));

    // Write IP 0, minimum round trip
    delay[0] = 1; a0 = ack_cnt;
    do_txn("wr_ip0", 32'h0000_0004, 1'b1, 32'hA5A5_A5A5, 4'b0011, '0, 1'b0, 3'b001, 3, 0);
    check_val("wr_ip0_adr", 64'(obs_adr), 64'(32'h0000_0004));
    check_val("wr_ip0_dat", 64'(obs_dat), 64'(32'hA5A5_A5A5));
    check_val("wr_ip0_sel", 64'(obs_sel), 64'(4'b0011));
    check_val("wr_ip0_we", 64'(obs_we), 64'(1));
    check_val("wr_ip0_acks", 64'(ack_cnt - a0), 64'(1));
    check_val("wr_ip0_txn", 64'(txn_count_o), 64'(2));

    clear_pulse();
    check_val("clear_txn", 64'(txn_count_o), 64'(0));

    // IP 1 never acks: watchdog fires after TO strobe cycles
    delay[1] = 0; a0 = ack_cnt; e0 = err_cnt; s0 = stb1_cnt;
    do_txn("to_ip1", 32'h4000_0020, 1'b0, '0, 4'hF, ERR, 1'b1, 3'b010, TO + 2, 0);
    check_val("to_stb_cycles", 64'(stb1_cnt - s0), 64'(TO));
    check_val("to_hang", 64'(hang_flags_o), 64'(3'b010));
    check_val("to_count", 64'(timeout_count_o), 64'(1));
    check_val("to_err", 64'(err_cnt - e0), 64'(1));
    check_val("to_acks", 64'(ack_cnt - a0), 64'(1));
    check_val("to_txn", 64'(txn_count_o), 64'(1));
    a0 = ack_cnt;
    @(posedge clk); #1 extra_ack = 3'b010;
    repeat (2) @(posedge clk);
    #1 extra_ack = '0;
    repeat (2) @(posedge clk);
    #1;
    check_val("late_ack_ign", 64'(ack_cnt - a0), 64'(0));
    check_val("late_ack_txn", 64'(txn_count_o), 64'(1));

    // Unmapped selector 3
    e0 = err_cnt;
    do_txn("dec_err", 32'hC000_0000, 1'b0, '0, 4'hF, ERR, 1'b1, 3'b000, 2, 0);
    check_val("dec_err_err", 64'(err_cnt - e0), 64'(1));
    check_val("dec_err_to", 64'(timeout_count_o), 64'(1));
    check_val("dec_err_txn", 64'(txn_count_o), 64'(2));

    // Abort: master drops cycle two cycles into ACTIVE
    a0 = ack_cnt; e0 = err_cnt;
    @(posedge clk); #1;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = 32'h4000_0000;
    @(posedge clk);
    @(negedge clk);
    check_val("abort_stb_on", 64'(ip_stb_o), 64'(3'b010));
    @(posedge clk); #1;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    @(posedge clk); #1;
    check_val("abort_drop", 64'({ip_cyc_o, ip_stb_o}), 64'(0));
    repeat (3) @(posedge clk);
    #1;
    check_val("abort_noack", 64'(ack_cnt - a0), 64'(0));
    check_val("abort_stats", 64'({txn_count_o, timeout_count_o}), 64'({2'd2, 2'd1}));
    check_val("abort_noerr", 64'(err_cnt - e0), 64'(0));
    ip_dat[2*DW +: DW] = 32'hCAFE_F00D;
    do_txn("post_abort", 32'h8000_0100, 1'b0, '0, 4'hF, 32'hCAFE_F00D, 1'b1, 3'b100, 5, 0);
    check_val("post_abort_txn", 64'(txn_count_o), 64'(3));

    // Saturation of a 2-bit counter, then clear coinciding with an ack
    clear_pulse();
    delay[0] = 2; ip_dat[0 +: DW] = 32'h0BAD_C0DE;
    for (int i = 0; i < 4; i++)
      do_txn("sat_rd", 32'h0000_0040 + 32'(i * 4), 1'b0, '0, 4'hF, 32'h0BAD_C0DE, 1'b1, 3'b001, 4, 0);
    do_txn("sat_to", 32'h4000_0000, 1'b0, '0, 4'hF, ERR, 1'b1, 3'b010, TO + 2, 0);
    check_val("sat_txn", 64'(txn_count_o), 64'(3));
    check_val("sat_hang", 64'(hang_flags_o), 64'(3'b010));
    do_txn("clr_ack", 32'h0000_0080, 1'b0, '0, 4'hF, 32'h0BAD_C0DE, 1'b1, 3'b001, 4, 1);
    check_val("clr_txn", 64'(txn_count_o), 64'(0));
    check_val("clr_hang", 64'(hang_flags_o), 64'(0));
    check_val("clr_to", 64'(timeout_count_o), 64'(0));

    // Reset in the middle of a transaction
    a0 = ack_cnt;
    @(posedge clk); #1;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_adr_i = 32'h4000_0000;
    @(posedge clk);
    @(negedge clk);
    check_val("mrst_stb_on", 64'(ip_stb_o), 64'(3'b010));
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    check_val("mrst_drop", 64'({ip_cyc_o, ip_stb_o, wbs_ack_o}), 64'(0));
    rst = 1'b0; wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_val("mrst_noack", 64'(ack_cnt - a0), 64'(0));
    do_txn("post_rst", 32'h8000_0000, 1'b0, '0, 4'hF, 32'hCAFE_F00D, 1'b1, 3'b100, 5, 0);
    check_val("post_rst_txn", 64'(txn_count_o), 64'(1));
    check_val("sb_empty", 64'(sb.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
